// File: rtl/soc_io_pkg.sv
// Shared SOC IO definitions: IO word-address decode bits, UART status bit and
// UART timing constants, plus the write-request bundle used by the merge FIFO.
package soc_io_pkg;

    // One-hot IO word-address bit indices
    localparam int IO_LEDS     = 0;
    localparam int IO_UART_DAT = 1;
    localparam int IO_UART_CTL = 2;
    localparam int IO_HALT     = 3;

    localparam int UART_BUSY_BIT = 9;

    localparam int UART_CLK_HZ = 50_000_000;
    localparam int UART_BAUD   = 230400;

    typedef struct packed {
        logic       wr;
        logic [7:0] data;
    } io_wr_t;

endpackage

// File: rtl/io_fifo_dw_mem.sv
// DEPTH x 8 register array with two write ports and one asynchronous read port.
// Storage is deliberately not reset; occupancy tracking lives in the owner.
module io_fifo_dw_mem #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [7:0]    wd1,
    input  logic          we2,
    input  logic [AW-1:0] wa2,
    input  logic [7:0]    wd2,
    input  logic [AW-1:0] ra,
    output logic [7:0]    rd
);

    logic [DEPTH-1:0][7:0] mem;

    // Port 1 wins on an address clash; the owner never produces one.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we1 && (wa1 == AW'(i)))
                mem[i] <= wd1;
            else if (we2 && (wa2 == AW'(i)))
                mem[i] <= wd2;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/io_uart_merge_fifo.sv
// Merges the two IO byte-write ports of the dual-issue core into one in-order
// stream for the UART (A older than B), and exports busy/occupancy/overflow.
module io_uart_merge_fifo
    import soc_io_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        a_wr,
    input  logic [7:0]  a_data,
    input  logic        b_wr,
    input  logic [7:0]  b_data,
    output logic        uart_valid,
    output logic [7:0]  uart_data,
    input  logic        uart_ready,
    output logic        busy,
    output logic [AW:0] count,
    output logic        overflow
);

    localparam int          CW      = AW + 1;
    localparam logic [AW:0] DEPTH_C = CW'(DEPTH);

    io_wr_t        req_a, req_b;
    logic [AW-1:0] wr_ptr, rd_ptr, wa2;
    logic [AW:0]   cnt, cnt_next, free;
    logic          ovf, busy_q;
    logic          pop, acc_a, acc_b, drop;
    logic          we1, we2;
    logic [7:0]    wd1;
    logic [1:0]    n_acc;

    assign req_a = '{wr: a_wr, data: a_data};
    assign req_b = '{wr: b_wr, data: b_data};

    // free is taken from the registered count, so a same-cycle pop never
    // makes room for a push. With one slot left, A (older) takes it.
    always_comb begin
        free     = DEPTH_C - cnt;
        pop      = (cnt != '0) && uart_ready;
        acc_a    = req_a.wr && (free != '0);
        acc_b    = req_b.wr && (req_a.wr ? (free >= CW'(2)) : (free != '0));
        drop     = (req_a.wr && !acc_a) || (req_b.wr && !acc_b);
        n_acc    = {1'b0, acc_a} + {1'b0, acc_b};
        cnt_next = cnt + CW'(n_acc) - CW'(pop);
        we1      = acc_a || acc_b;
        wd1      = acc_a ? req_a.data : req_b.data;
        we2      = acc_a && acc_b;
        wa2      = wr_ptr + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_acc);
            rd_ptr <= rd_ptr + AW'(pop);
            cnt    <= cnt_next;
            busy_q <= (DEPTH_C - cnt_next) < CW'(2);
            if (drop)
                ovf <= 1'b1;
        end
    end

    io_fifo_dw_mem #(.DEPTH(DEPTH)) u_mem (
        .clk (clk),
        .we1 (we1),
        .wa1 (wr_ptr),
        .wd1 (wd1),
        .we2 (we2),
        .wa2 (wa2),
        .wd2 (req_b.data),
        .ra  (rd_ptr),
        .rd  (uart_data)
    );

    assign uart_valid = (cnt != '0);
    assign busy       = busy_q;
    assign count      = cnt;
    assign overflow   = ovf;

endmodule
